// File: rtl/rv_pkg.sv
// Shared definitions for the integer register-file writeback slice.
//   - load funct3 encodings (LB/LH/LW/LBU/LHU)
//   - NREG: number of architectural integer registers
//   - reg_idx_t / word_t: register index and data word types
package rv_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and sign/zero extension (combinational).
// Ports:
//   rdata  in  32  raw aligned memory word
//   funct3 in  3   load type (unknown encodings behave as LW)
//   off    in  2   byte offset within the word
//   ext    out 32  value to write to the register file
// Misaligned halfword offsets are not trapped; bits above the word read as zero.
module load_ext
  import rv_pkg::*;
(
  input  word_t       rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output word_t       ext
);

  word_t shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  ext = {24'h0, shifted[7:0]};
      F3_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  ext = {16'h0, shifted[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writer side of the integer register file.
//   - Fixed-priority arbitration of LSU load results over ALU results into
//     the single RF write port, registered (one cycle latency).
//   - Per-register pending-write counters: issue increments, RF write
//     decrements; decode queries them for RAW hazards (busy1/busy2).
// Ports:
//   clk, rst                      clock, async active-high reset
//   iss_valid/iss_rd/iss_ready    destination registration from issue
//   alu_valid/alu_rd/alu_data/alu_ready            ALU result channel
//   lsu_valid/lsu_rd/lsu_rdata/lsu_funct3/lsu_off/lsu_ready  load channel
//   rf_we/rf_waddr/rf_wdata       register file write port
//   qaddr1/2 -> busy1/2           hazard queries
//   fwd1/2_valid, fwd1/2_data     bypass of the write in flight
// Optional feature macro: REGFILE_WB_BYPASS_EN (forwarding of the rf_we
// cycle's data; tied to zero when undefined).
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_off,
  output logic                  lsu_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] qaddr1,
  input  logic [ADDR_WIDTH-1:0] qaddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  fwd1_valid,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data
);

  localparam int unsigned          NR      = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NR];
  logic [CNT_WIDTH-1:0]  cnt_d [NR];
  word_t                 ld_data;
  logic                  iss_fire;

  load_ext u_load_ext (
    .rdata  (word_t'(lsu_rdata)),
    .funct3 (lsu_funct3),
    .off    (lsu_off),
    .ext    (ld_data)
  );

  assign lsu_ready = 1'b1;
  assign alu_ready = !lsu_valid;

  // A saturated counter can still accept an issue when its own write
  // retires this cycle: the two events cancel in the counter update.
  assign iss_ready = (iss_rd == '0) || (cnt_q[iss_rd] != CNT_MAX) ||
                     (rf_we_q && (rf_waddr_q == iss_rd));
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  // Address/data only move on a real write, so they hold otherwise.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (lsu_valid) begin
      if (lsu_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = lsu_rd;
        rf_wdata_d = DATA_WIDTH'(ld_data);
      end
    end else if (alu_valid && (alu_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    for (int unsigned i = 1; i < NR; i++) begin : g_cnt
      logic inc, dec;
      inc = iss_fire && (iss_rd == ADDR_WIDTH'(i));
      dec = rf_we_q && (rf_waddr_q == ADDR_WIDTH'(i));
      if (inc && !dec)
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec && !inc && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int unsigned i = 0; i < NR; i++) cnt_q[i] <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // A retiring write with no pending registration is a protocol error.
  always_ff @(posedge clk) begin
    if (!rst && rf_we_q) assert (cnt_q[rf_waddr_q] != '0);
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1_valid = rf_we_q && (rf_waddr_q == qaddr1) && (qaddr1 != '0);
  assign fwd2_valid = rf_we_q && (rf_waddr_q == qaddr2) && (qaddr2 != '0);
  assign fwd1_data  = rf_wdata_q;
  assign fwd2_data  = rf_wdata_q;
  // The retiring write is forwarded, so it no longer counts as pending.
  assign busy1 = (cnt_q[qaddr1] - CNT_WIDTH'(fwd1_valid)) != '0;
  assign busy2 = (cnt_q[qaddr2] - CNT_WIDTH'(fwd2_valid)) != '0;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
  assign busy1 = cnt_q[qaddr1] != '0;
  assign busy2 = cnt_q[qaddr2] != '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_off;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  qaddr1, qaddr2;
  logic        busy1, busy2, fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_funct3(lsu_funct3), .lsu_off(lsu_off), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .qaddr1(qaddr1), .qaddr2(qaddr2), .busy1(busy1), .busy2(busy2),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: pending writes per register, the write expected on the
  // RF port, and (random phase) results still owed per register.
  int          pend [32];
  int          owed [32];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [2:0]  f3tab [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
  bit          ia, aa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    longint unsigned sh, b, h;
    logic [31:0] r;
    sh = {32'h0, w} / (64'd1 << (8 * off));
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'b000: begin r = 32'(b); if (b >= 128) r = r - 32'd256; end
      3'b100: r = 32'(b);
      3'b001: begin r = 32'(h); if (h >= 32768) r = r - 32'd65536; end
      3'b101: r = 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic exp_fwd(input logic [4:0] q);
`ifdef REGFILE_WB_BYPASS_EN
    return m_we && (m_wa == q) && (q != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_busy(input logic [4:0] q);
    int fv;
    fv = exp_fwd(q) ? 1 : 0;
    return (pend[q] - fv) != 0;
  endfunction

  // One clock: check combinational outputs, advance the model at the edge,
  // then check the registered write port.
  task automatic cycle(output bit iss_acc, output bit alu_acc);
    logic        exp_ir, acc;
    logic [4:0]  ard, ird;
    logic [31:0] adat, fd;
    #1;
    ird    = iss_rd;
    exp_ir = (ird == 0) || (pend[ird] < 3) || (m_we && m_wa == ird);
    chk("iss_ready", iss_ready, exp_ir);
    chk("alu_ready", alu_ready, !lsu_valid);
    chk("lsu_ready", lsu_ready, 1);
    chk("busy1", busy1, exp_busy(qaddr1));
    chk("busy2", busy2, exp_busy(qaddr2));
    chk("fwd1_valid", fwd1_valid, exp_fwd(qaddr1));
    chk("fwd2_valid", fwd2_valid, exp_fwd(qaddr2));
`ifdef REGFILE_WB_BYPASS_EN
    fd = m_wd;
`else
    fd = '0;
`endif
    chk("fwd1_data", fwd1_data, fd);
    chk("fwd2_data", fwd2_data, fd);
    iss_acc = !rst && iss_valid && exp_ir && (ird != 0);
    alu_acc = !rst && alu_valid && !lsu_valid;
    acc = 1'b0; ard = '0; adat = '0;
    if (!rst && lsu_valid) begin
      acc = 1'b1; ard = lsu_rd; adat = ref_ext(lsu_funct3, lsu_off, lsu_rdata);
    end else if (alu_acc) begin
      acc = 1'b1; ard = alu_rd; adat = alu_data;
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (m_we) pend[m_wa]--;
      if (iss_acc) pend[ird]++;
      if (acc && ard != 0) begin m_we = 1'b1; m_wa = ard; m_wd = adat; end
      else m_we = 1'b0;
    end
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_wa);
    chk("rf_wdata", rf_wdata, m_wd);
  endtask

  task automatic issue(input logic [4:0] rd);
    bit a, b;
    iss_valid = 1'b1; iss_rd = rd;
    cycle(a, b);
    iss_valid = 1'b0;
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] d);
    bit a, b;
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    cycle(a, b);
    alu_valid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] w, input logic [31:0] exp);
    bit a, b;
    issue(5'd10);
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_funct3 = f3; lsu_off = off; lsu_rdata = w;
    cycle(a, b);
    lsu_valid = 1'b0;
    chk(tag, rf_wdata, exp);
    cycle(a, b);
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 0; iss_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_off = 0;
    qaddr1 = 0; qaddr2 = 0;
    model_reset();
    cycle(ia, aa);
    cycle(ia, aa);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_iss_ready", iss_ready, 1);
    rst = 1'b0;
    cycle(ia, aa);

    // LSU wins over ALU; ALU is held and written the cycle after.
    issue(5'd5);
    issue(5'd6);
    qaddr1 = 5; qaddr2 = 6;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 6; lsu_funct3 = 3'b010; lsu_off = 0; lsu_rdata = 32'h22;
    #1 chk("prio_alu_ready", alu_ready, 0);
    cycle(ia, aa);
    lsu_valid = 0;
    chk("prio_we_lsu", rf_we, 1);
    chk("prio_waddr_lsu", rf_waddr, 6);
    chk("prio_wdata_lsu", rf_wdata, 32'h22);
    cycle(ia, aa);
    alu_valid = 0;
    chk("prio_waddr_alu", rf_waddr, 5);
    chk("prio_wdata_alu", rf_wdata, 32'h11);
    cycle(ia, aa);

    // Load extension.
    load_case("ld_lb_off1",  3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F);
    load_case("ld_lbu_off1", 3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F);
    load_case("ld_lb_off2",  3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF);
    load_case("ld_lh_off2",  3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF);
    load_case("ld_lhu_off2", 3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF);
    load_case("ld_lhu_off3", 3'b101, 2'd3, 32'h80FF7F01, 32'h00000080);

    // Writes to x0 are accepted but dropped.
    qaddr1 = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    #1 chk("x0_alu_ready", alu_ready, 1);
    cycle(ia, aa);
    alu_valid = 0;
    chk("x0_we", rf_we, 0);
    chk("x0_busy", busy1, 0);

    // Scoreboard saturation on x7.
    qaddr1 = 7;
    issue(5'd7); issue(5'd7); issue(5'd7);
    iss_valid = 1; iss_rd = 7;
    #1 chk("sat_ready", iss_ready, 0);
    cycle(ia, aa);
    iss_valid = 0;
    alu_write(5'd7, 32'h70);
    #1 chk("sat_reenable", iss_ready, 1);
    chk("sat_busy_1", busy1, 1);
    alu_write(5'd7, 32'h71);
    alu_write(5'd7, 32'h72);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("sat_busy_last", busy1, 0);
`else
    chk("sat_busy_last", busy1, 1);
`endif
    cycle(ia, aa);
    chk("sat_busy_done", busy1, 0);

    // Reset while a write is in flight and x3 has two pending.
    issue(5'd3); issue(5'd3); issue(5'd4);
    alu_write(5'd4, 32'h44);
    chk("mid_we_pre", rf_we, 1);
    qaddr2 = 3; iss_rd = 3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_we", rf_we, 0);
    chk("mid_busy3", busy2, 0);
    chk("mid_iss_ready", iss_ready, 1);
    cycle(ia, aa);
    rst = 1'b0;
    cycle(ia, aa);

    // Bypass of the final pending write.
    qaddr1 = 9;
    issue(5'd9);
    alu_write(5'd9, 32'h1234);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_fwd_valid", fwd1_valid, 1);
    chk("byp_fwd_data", fwd1_data, 32'h1234);
    chk("byp_busy", busy1, 0);
`else
    chk("byp_busy", busy1, 1);
    chk("byp_fwd_valid", fwd1_valid, 0);
`endif
    cycle(ia, aa);

    // Randomized traffic over x0..x7; results only for issued registers.
    rst = 1'b1;
    for (int i = 0; i < 32; i++) owed[i] = 0;
    #1 model_reset();
    cycle(ia, aa);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      if (!alu_valid && ($urandom_range(0, 1) == 1)) begin
        r = 5'($urandom_range(0, 7));
        if (r == 0 || owed[r] > 0) begin
          alu_valid = 1; alu_rd = r; alu_data = $urandom;
          if (r != 0) owed[r]--;
        end
      end
      lsu_valid = 0;
      if ($urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(0, 7));
        if (r == 0 || owed[r] > 0) begin
          lsu_valid = 1; lsu_rd = r; lsu_rdata = $urandom;
          lsu_funct3 = f3tab[$urandom_range(0, 6)];
          lsu_off = 2'($urandom_range(0, 3));
          if (r != 0) owed[r]--;
        end
      end
      qaddr1 = 5'($urandom_range(0, 7));
      qaddr2 = 5'($urandom_range(0, 7));
      cycle(ia, aa);
      if (ia) owed[iss_rd]++;
      if (aa) alu_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
